// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a common-anode 4-digit seven-segment display.
// Digits are snapshotted once per scan frame; supports blink, leading-zero blanking and DP.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ENABLE,
  input  logic [3:0] DIGIT_3,
  input  logic [3:0] DIGIT_2,
  input  logic [3:0] DIGIT_1,
  input  logic [3:0] DIGIT_0,
  input  logic [3:0] BLINK_MASK,
  input  logic       LZB,
  input  logic       DP_EN,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP
);

  localparam int DIV_W = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_ph_q, blink_ph_d;
  logic [3:0][3:0]  shadow_q, shadow_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic tick, frame_end, visible;
  logic [3:0] cur_digit;

  // Active-low segment pattern, bit0 = a ... bit6 = g.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it unassigned (no latch).
    div_cnt_d   = div_cnt_q + 1'b1;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    blink_ph_d  = blink_ph_q;
    shadow_d    = shadow_q;

    tick      = (div_cnt_q == DIV_LAST);
    frame_end = tick && (idx_q == 2'd3);

    if (tick) begin
      div_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end

    // Snapshot at the frame boundary so a frame never shows mixed old/new digits.
    if (frame_end) begin
      shadow_d = {DIGIT_3, DIGIT_2, DIGIT_1, DIGIT_0};
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    cur_digit = shadow_q[idx_q];
    visible   = ENABLE
             && !(BLINK_MASK[idx_q] && blink_ph_q)
             && !((idx_q == 2'd3) && LZB && (shadow_q[3] == 4'h0));

    an_d  = 4'b1111;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (visible) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(cur_digit);
      dp_d  = !((idx_q == 2'd2) && DP_EN);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_q   <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      // NOTE: the shadow digits are reset too, so the first frame after reset shows 0s.
      shadow_q    <= '0;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      blink_ph_q  <= blink_ph_d;
      shadow_q    <= shadow_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against a cycle-count based reference model.
module tb_seg_scan_driver;

  localparam int R = 4;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] d3, d2, d1, d0;
  logic [3:0] blink_mask;
  logic       lzb, dp_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: edges since reset release, plus the digits captured at the last boundary.
  int         k;
  logic [3:0] m_shadow [4];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_driver #(.REFRESH_DIV(R), .BLINK_FRAMES(B)) dut (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable),
    .DIGIT_3(d3), .DIGIT_2(d2), .DIGIT_1(d1), .DIGIT_0(d0),
    .BLINK_MASK(blink_mask), .LZB(lzb), .DP_EN(dp_en),
    .AN(an), .SEG(seg), .DP(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t, k=%0d)", tag, obs, exp, $time, k);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 4; i++) m_shadow[i] = 4'h0;
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_an"},  {28'd0, an},  32'hF);
    check({tag, "_seg"}, {25'd0, seg}, 32'h7F);
    check({tag, "_dp"},  {31'd0, dp},  32'h1);
  endtask

  // One clock: predict from the pre-edge model and live inputs, step, then compare on the negedge.
  task automatic cycle();
    int         idx, frames, blink;
    bit         vis;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    idx    = (k / R) % 4;
    frames = k / (4 * R);
    blink  = (frames / B) % 2;
    vis    = enable && !(blink_mask[idx] && blink == 1)
                    && !(idx == 3 && lzb && m_shadow[3] == 4'h0);
    e_an  = vis ? ~(4'b0001 << idx) : 4'b1111;
    e_seg = vis ? seg_tab[m_shadow[idx]] : 7'h7F;
    e_dp  = (vis && idx == 2 && dp_en) ? 1'b0 : 1'b1;
    @(posedge clk);
    if ((k % (4 * R)) == 4 * R - 1) begin
      m_shadow[3] = d3; m_shadow[2] = d2; m_shadow[1] = d1; m_shadow[0] = d0;
    end
    k++;
    @(negedge clk);
    check("an",  {28'd0, an},  {28'd0, e_an});
    check("seg", {25'd0, seg}, {25'd0, e_seg});
    check("dp",  {31'd0, dp},  {31'd0, e_dp});
    check("an_onehot", {31'd0, ($countones(~an) <= 1)}, 32'd1);
  endtask

  // Reset asserted between edges must blank the outputs without a clock.
  task automatic mid_slot_reset();
    #2 rst_n = 1'b0;
    #1 check_blank("async_rst");
    @(negedge clk);
    check_blank("rst_hold");
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1;
    d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
    blink_mask = 4'b0000; lzb = 1'b0; dp_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_blank("reset");
    rst_n = 1'b1;

    // Two frames of 1,2,3,4: first frame shows zeros, second the captured digits.
    repeat (32) cycle();
    // Mid-frame change of digit 0 is held off until the next boundary.
    repeat (6) cycle();
    d0 = 4'd9;
    repeat (30) cycle();
    // Blink on digits 0 and 1 across several blink periods.
    blink_mask = 4'b0011;
    repeat (80) cycle();
    blink_mask = 4'b0000;
    // Leading-zero blanking and DP on digit 2, then LZB off.
    d3 = 4'd0; d2 = 4'd5; lzb = 1'b1; dp_en = 1'b1;
    repeat (32) cycle();
    lzb = 1'b0;
    repeat (32) cycle();
    // Display disabled for 10 cycles while the divider keeps running.
    enable = 1'b0;
    repeat (10) cycle();
    enable = 1'b1;
    repeat (20) cycle();
    mid_slot_reset();
    repeat (20) cycle();

    // Randomized mix of digit, mask, blanking and enable changes with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        d3 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        d2 = 4'($urandom); d1 = 4'($urandom); d0 = 4'($urandom);
      end
      if ($urandom_range(0, 40) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 30) == 0) lzb = 1'($urandom);
      if ($urandom_range(0, 20) == 0) dp_en = 1'($urandom);
      if ($urandom_range(0, 25) == 0) enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 400) == 0) mid_slot_reset();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Consumes the four selected BCD/hex digits (SEL_3..SEL_0) from the display-select mux and drives a common-anode 4-digit seven-segment display by time-multiplexed scanning.
- Snapshots the digits once per scan frame so a frame never tears.
- Supports a per-digit blink mask (alarm/time-set editing), leading-zero blanking of digit 3, and a colon/decimal point on digit 2.
- Sits between the display mux and the board pins.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit is lit (minimum 2).
- BLINK_FRAMES, 64: full scan frames per blink half-period (minimum 1).

Ports:
- CLK  input  1  system clock
- RST_N  input  1  asynchronous active-low reset
- ENABLE  input  1  1 = display on; 0 = all anodes off (counters keep running)
- DIGIT_3  input  4  most significant displayed digit (from SEL_3)
- DIGIT_2  input  4  from SEL_2
- DIGIT_1  input  4  from SEL_1
- DIGIT_0  input  4  least significant digit (from SEL_0)
- BLINK_MASK  input  4  bit n = 1: digit n blinks
- LZB  input  1  1 = blank digit 3 when its snapshot value is 0
- DP_EN  input  1  1 = light DP while digit 2 is scanned
- AN  output  4  anode enables, active-low, bit n = digit n
- SEG  output  7  segments, active-low, bit0 = a … bit6 = g
- DP  output  1  decimal point, active-low

Behaviour:
- Reset (RST_N = 0, asynchronous) sets:
  - Outputs: AN = 4'b1111, SEG = 7'h7F, DP = 1.
  - Internal state: div_cnt = 0, idx = 0, frame_cnt = 0, blink_ph = 0, all four shadow digits = 0.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1.
  - tick = (div_cnt == REFRESH_DIV-1).
  - On tick: div_cnt returns to 0 and idx increments mod 4. Scan order is 0,1,2,3,0,…
- Frame boundary: tick while idx == 3.
  - On the same edge, the shadow registers capture DIGIT_3..DIGIT_0.
  - frame_cnt increments. If frame_cnt == BLINK_FRAMES-1, it wraps to 0 and blink_ph toggles.
- Digit visibility: digit idx is visible iff ALL of:
  - ENABLE = 1;
  - NOT (BLINK_MASK[idx] and blink_ph = 1);
  - NOT (idx = 3 and LZB and shadow_3 = 0).
  - BLINK_MASK, LZB, DP_EN and ENABLE are sampled live every cycle; they are not snapshotted.
- Output register: loaded every cycle from the current idx and shadow state, so outputs lag idx by 1 clock.
  - AN = ~(4'b0001 << idx) if visible, else 4'b1111.
  - SEG = decode(shadow_idx) if visible, else 7'h7F.
  - DP = 0 iff visible and idx == 2 and DP_EN, else 1.
- Decode, hex value → SEG:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- Boundary conditions:
  - Input changes mid-frame do not appear until the next frame boundary.
  - Exactly one AN bit is low at any time, or none.
  - Reset asserted mid-frame blanks the outputs immediately. After release, scanning restarts at digit 0 showing 0s until the first frame boundary.
  - A blink toggle and a digit capture on the same edge both take effect.

Test Plan (REFRESH_DIV=4, BLINK_FRAMES=2):
1. Reset release, ENABLE=1, DIGIT_3..0=1,2,3,4:
   - First frame shows 0 on every digit: AN 1110, 1101, 1011, 0111, 4 cycles each, SEG=40.
   - Second frame: AN=1110 with SEG=19, then SEG=30, SEG=24, SEG=79.
2. Change DIGIT_0 from 4 to 9 while digit 1 is being scanned:
   - Digit 0 keeps showing SEG=19 for the rest of the frame.
   - SEG=10 appears on the first digit-0 slot after the boundary.
3. BLINK_MASK=4'b0011:
   - Digits 0 and 1 are lit for 2 frames, then AN=1111 in their slots for 2 frames, repeating.
   - Digits 2 and 3 stay lit throughout.
4. LZB=1, DIGIT_3=0, DIGIT_2=5, DP_EN=1:
   - Digit-3 slot has AN=1111.
   - Digit-2 slot has AN=1011, SEG=12, DP=0.
   - With LZB=0 instead, digit 3 shows SEG=40.
5. ENABLE=0 for 10 cycles:
   - AN=1111, SEG=7F, DP=1 throughout.
   - On re-enable, scan position is consistent with the divider that kept running.
6. Assert RST_N=0 mid-slot:
   - Outputs go to 1111/7F/1 without waiting for CLK.
   - After release, digit 0 shows SEG=40.
